// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the pipeline stage registers.
//   skid_state_e : occupancy state of a two-entry skid stage register
//                  (EMPTY=0, ONE=1, FULL=2)
//   NOP_PAYLOAD  : default bubble payload (all zeros)
//   state_count  : number of held entries for a given state
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   localparam logic [63:0] NOP_PAYLOAD = 64'd0;

   function automatic logic [1:0] state_count(input skid_state_e st);
      logic [1:0] cnt;
      cnt = 2'd0;
      case (st)
         ST_EMPTY: cnt = 2'd0;
         ST_ONE:   cnt = 2'd1;
         ST_FULL:  cnt = 2'd2;
         default:  cnt = 2'd0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry (main + skid) pipeline stage register with valid/ready handshakes.
// Used as IF/ID, ID/EX, EX/MEM and MEM/WB registers by choosing NB_DATA.
//
// Handshake: a transfer happens on a rising edge only when valid and ready are
// both high in that cycle (and i_dunit_clk_en is high). o_ready and o_valid
// depend only on registered state and i_dunit_clk_en, never on i_valid or
// i_ready, so stages can be chained without combinational loops.
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         asynchronous active-high reset
//   i_dunit_clk_en  debug-unit enable; 0 freezes all state and masks handshakes
//   i_flush         synchronous flush; drops held entries and same-cycle input
//   i_valid/i_data  upstream payload
//   o_ready         stage can accept a payload this cycle
//   o_valid/o_data  downstream payload (RST_DATA when empty)
//   i_ready         downstream accepts the payload
//   o_count         registered number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int                   NB_DATA  = 64,
   parameter logic [NB_DATA-1:0]   RST_DATA = NB_DATA'(NOP_PAYLOAD)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_dunit_clk_en,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_data,
   output logic               o_ready,
   output logic               o_valid,
   output logic [NB_DATA-1:0] o_data,
   input  logic               i_ready,
   output logic [1:0]         o_count
);

   skid_state_e        state_q, state_d;
   logic [NB_DATA-1:0] main_q, main_d;
   logic [NB_DATA-1:0] skid_q, skid_d;
   logic [1:0]         count_q, count_d;
   logic               in_xfer;
   logic               out_xfer;

   assign o_ready  = (state_q != ST_FULL)  & i_dunit_clk_en;
   assign o_valid  = (state_q != ST_EMPTY) & i_dunit_clk_en;
   // main is not cleared when draining to EMPTY, so the bubble value is muxed here
   assign o_data   = (state_q == ST_EMPTY) ? RST_DATA : main_q;
   assign o_count  = count_q;

   // Both already include i_dunit_clk_en through o_ready/o_valid
   assign in_xfer  = i_valid & o_ready;
   assign out_xfer = o_valid & i_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_DATA;
         skid_q  <= RST_DATA;
         count_q <= 2'd0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (!i_dunit_clk_en) begin
         // frozen: hold everything, flush ignored
         state_d = state_q;
      end else if (i_flush) begin
         // flush wins over any transfer in the same cycle
         state_d = ST_EMPTY;
         main_d  = RST_DATA;
         skid_d  = RST_DATA;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_d  = i_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d  = i_data;
               end else if (in_xfer) begin
                  // downstream stalled: park the new payload behind main
                  skid_d  = i_data;
                  state_d = ST_FULL;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // o_ready is low here, so no input can arrive
               if (out_xfer) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = RST_DATA;
               skid_d  = RST_DATA;
            end
         endcase
      end

      count_d = state_count(state_d);
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

   localparam int              NB  = 16;
   localparam logic [NB-1:0]   RST = 16'hDEAD;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_dunit_clk_en;
   logic          i_flush;
   logic          i_valid;
   logic [NB-1:0] i_data;
   logic          o_ready;
   logic          o_valid;
   logic [NB-1:0] o_data;
   logic          i_ready;
   logic [1:0]    o_count;

   int checks   = 0;
   int failures = 0;

   pipe_skid_reg #(.NB_DATA(NB), .RST_DATA(RST)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_dunit_clk_en (i_dunit_clk_en),
      .i_flush        (i_flush),
      .i_valid        (i_valid),
      .i_data         (i_data),
      .o_ready        (o_ready),
      .o_valid        (o_valid),
      .o_data         (o_data),
      .i_ready        (i_ready),
      .o_count        (o_count)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   // advance one rising edge, then settle 1 ns away from it
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_dunit_clk_en = 1'b1; i_flush = 1'b0;
      i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
      tick(); tick();
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      checks++; if (o_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
      checks++; if (o_data !== RST) begin failures++; $display("FAIL reset_data got=%h exp=%h", o_data, RST); end
      i_reset = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
   endtask

   task automatic test_stream();
      i_valid = 1'b1; i_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         i_data = NB'(k);
         tick();
         checks++; if (o_data !== NB'(k)) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, o_data, NB'(k)); end
         checks++; if (o_valid !== 1'b1 || o_count !== 2'd1) begin failures++; $display("FAIL stream_state k=%0d valid=%b count=%0d exp valid=1 count=1", k, o_valid, o_count); end
      end
      i_valid = 1'b0;
      tick();
      checks++; if (o_count !== 2'd0 || o_valid !== 1'b0) begin failures++; $display("FAIL stream_drain count=%0d valid=%b exp 0/0", o_count, o_valid); end
   endtask

   task automatic fill_ab();
      i_ready = 1'b0; i_valid = 1'b1;
      i_data = 16'h000A; tick();
      i_data = 16'h000B; tick();
      i_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0; i_valid = 1'b1; i_data = 16'h000A;
      tick();
      checks++; if (o_count !== 2'd1 || o_data !== 16'h000A) begin failures++; $display("FAIL bp_one count=%0d data=%h exp 1/000a", o_count, o_data); end
      i_data = 16'h000B;
      tick();
      checks++; if (o_count !== 2'd2 || o_ready !== 1'b0) begin failures++; $display("FAIL bp_full count=%0d ready=%b exp 2/0", o_count, o_ready); end
      i_data = 16'h000C;
      tick();
      checks++; if (o_count !== 2'd2 || o_data !== 16'h000A) begin failures++; $display("FAIL bp_hold count=%0d data=%h exp 2/000a", o_count, o_data); end
      i_ready = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b1 || o_data !== 16'h000A) begin failures++; $display("FAIL bp_out_a valid=%b data=%h exp 1/000a", o_valid, o_data); end
      tick();
      checks++; if (o_data !== 16'h000B || o_count !== 2'd1 || o_ready !== 1'b1) begin failures++; $display("FAIL bp_out_b data=%h count=%0d ready=%b exp 000b/1/1", o_data, o_count, o_ready); end
      tick();
      checks++; if (o_data !== 16'h000C || o_valid !== 1'b1) begin failures++; $display("FAIL bp_out_c data=%h valid=%b exp 000c/1", o_data, o_valid); end
      i_valid = 1'b0;
      tick();
      checks++; if (o_count !== 2'd0) begin failures++; $display("FAIL bp_drain count=%0d exp=0", o_count); end
   endtask

   task automatic test_flush();
      fill_ab();
      i_flush = 1'b1; i_valid = 1'b1; i_data = 16'h000C;
      tick();
      checks++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_data !== RST) begin failures++; $display("FAIL flush count=%0d valid=%b data=%h exp 0/0/%h", o_count, o_valid, o_data, RST); end
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_drop cyc=%0d valid=%b data=%h exp valid=0", k, o_valid, o_data); end
      end
   endtask

   task automatic test_clk_en();
      fill_ab();
      i_dunit_clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_ready = k[0] ? 1'b0 : 1'b1;
         i_flush = k[0] ? 1'b1 : 1'b0;
         tick();
         checks++; if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_count !== 2'd2) begin failures++; $display("FAIL en_freeze cyc=%0d ready=%b valid=%b count=%0d exp 0/0/2", k, o_ready, o_valid, o_count); end
      end
      i_flush = 1'b0; i_ready = 1'b1; i_valid = 1'b0; i_dunit_clk_en = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b1 || o_data !== 16'h000A) begin failures++; $display("FAIL en_resume_a valid=%b data=%h exp 1/000a", o_valid, o_data); end
      tick();
      checks++; if (o_data !== 16'h000B || o_count !== 2'd1) begin failures++; $display("FAIL en_resume_b data=%h count=%0d exp 000b/1", o_data, o_count); end
      tick();
      checks++; if (o_count !== 2'd0) begin failures++; $display("FAIL en_drain count=%0d exp=0", o_count); end
   endtask

   task automatic test_async_reset();
      i_ready = 1'b0; i_valid = 1'b1; i_data = 16'h0055;
      tick();
      i_valid = 1'b0;
      checks++; if (o_count !== 2'd1) begin failures++; $display("FAIL areset_pre count=%0d exp=1", o_count); end
      #2;
      i_reset = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin failures++; $display("FAIL areset_now valid=%b count=%0d exp 0/0", o_valid, o_count); end
      #1;
      i_reset = 1'b0;
      i_ready = 1'b1; i_valid = 1'b1; i_data = 16'h00D0;
      tick();
      checks++; if (o_valid !== 1'b1 || o_data !== 16'h00D0) begin failures++; $display("FAIL areset_first valid=%b data=%h exp 1/00d0", o_valid, o_data); end
      i_valid = 1'b0;
      tick();
      checks++; if (o_count !== 2'd0) begin failures++; $display("FAIL areset_drain count=%0d exp=0", o_count); end
   endtask

   task automatic test_random();
      logic [NB-1:0] exp_q[$];
      int            m_cnt;
      logic          in_f, out_f;
      logic [NB-1:0] exp_d;
      m_cnt = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 2) != 0);
         i_data  = NB'($urandom_range(0, 65535));
         #1;
         checks++;
         if (o_count !== 2'(m_cnt) || o_ready !== (m_cnt != 2) || o_valid !== (m_cnt != 0)) begin
            failures++;
            if (failures < 20) $display("FAIL rand_state cyc=%0d count=%0d ready=%b valid=%b exp count=%0d", cyc, o_count, o_ready, o_valid, m_cnt);
         end
         in_f  = i_valid && (m_cnt != 2);
         out_f = i_ready && (m_cnt != 0);
         if (out_f) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (o_data !== exp_d) begin
               failures++;
               if (failures < 20) $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, o_data, exp_d);
            end
         end
         if (in_f) exp_q.push_back(i_data);
         m_cnt = m_cnt + (in_f ? 1 : 0) - (out_f ? 1 : 0);
         tick();
      end
      i_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_clk_en();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter NB_DATA, default 64, meaning the payload width (e.g. PC+4 concatenated with instruction).
REQ-002 SHALL have parameter RST_DATA, default 0, meaning the payload value after reset or flush and the bubble value shown when empty.
REQ-003 SHALL have port i_clk  input  1  system clock; single clock domain, rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_dunit_clk_en  input  1  debug-unit enable; 0 freezes all state.
REQ-006 SHALL have port i_flush  input  1  synchronous flush; drops all held entries.
REQ-007 SHALL have port i_valid  input  1  upstream payload valid.
REQ-008 SHALL have port i_data  input  NB_DATA  upstream payload.
REQ-009 SHALL have port o_ready  output  1  block can accept a payload this cycle.
REQ-010 SHALL have port o_valid  output  1  downstream payload valid.
REQ-011 SHALL have port o_data  output  NB_DATA  downstream payload.
REQ-012 SHALL have port i_ready  input  1  downstream accepts the payload.
REQ-013 SHALL have port o_count  output  2  number of held entries (0..2).

Function
REQ-014 SHALL hold up to two entries (main, skid) and track them with a state machine EMPTY/ONE/FULL.
REQ-015 SHALL complete an input transfer only on a cycle with i_valid & o_ready & i_dunit_clk_en, and an output transfer only with o_valid & i_ready & i_dunit_clk_en.
REQ-016 SHALL drive o_ready = (state != FULL) & i_dunit_clk_en, with no combinational path from i_ready or i_valid.
REQ-017 SHALL drive o_valid = (state != EMPTY) & i_dunit_clk_en, and o_data = main register, or RST_DATA when EMPTY.
REQ-018 SHALL apply latency 1: data accepted at edge N appears on o_data with o_valid after edge N.
REQ-019 SHALL deliver payloads in acceptance order, with no loss or duplication.
REQ-020 EMPTY, input transfer: SHALL load main and go to ONE.
REQ-021 ONE, input only: SHALL load skid and go to FULL.
REQ-022 ONE, output only: SHALL go to EMPTY.
REQ-023 ONE, simultaneous input and output: SHALL reload main with i_data and stay ONE.
REQ-024 FULL, output transfer: SHALL move skid to main, go to ONE, and raise o_ready on the next cycle.
REQ-025 FULL: SHALL not accept input; i_data is ignored.
REQ-026 i_flush=1 with i_dunit_clk_en=1: SHALL go to EMPTY, set main/skid to RST_DATA, and drop the same-cycle input; flush overrides all transfers.
REQ-027 i_dunit_clk_en=0: SHALL hold state, data and count, and ignore i_flush.
REQ-028 SHALL drive o_count = 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-029 On asserted i_reset, independent of i_clk, SHALL force state EMPTY, main/skid = RST_DATA, o_count = 0, o_valid = 0.
REQ-030 After reset release, o_ready SHALL be 1 whenever i_dunit_clk_en=1.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries; the first payload after reset SHALL be the first one accepted after reset.

Structure
REQ-032 SHALL define the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) as constants in the shared package pipe_pkg, alongside the default NOP payload constant.
REQ-033 SHALL be a single module with no sub-module; the payload registers and control live inline.
REQ-034 SHALL be instantiable as the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers by setting NB_DATA.

Verification
REQ-035 Reset then stream: i_valid=1, i_ready=1, data 0x1..0x5 on consecutive cycles -> o_data 0x1..0x5 one cycle later each, o_count=1 throughout.
REQ-036 Backpressure: i_ready=0, push 0xA then 0xB -> o_count=2, o_ready=0, 0xC held off; then i_ready=1 -> outputs 0xA, 0xB, 0xC in order.
REQ-037 Flush with FULL (0xA, 0xB) plus i_valid with 0xC -> next cycle o_count=0, o_valid=0, o_data=RST_DATA; 0xC is never output.
REQ-038 i_dunit_clk_en=0 for 3 cycles while FULL, with toggled i_ready/i_flush -> no state change, o_ready=o_valid=0; on re-enable, 0xA is output first.
REQ-039 Async reset asserted between clock edges while ONE -> o_valid=0 and o_count=0 immediately, without a clock edge.
REQ-040 Random valid/ready, 10k cycles, scoreboard -> output sequence equals accepted sequence, o_count never exceeds 2.
